// File: rtl/ram_access_sequencer_if.sv
// Signal bundle between the RAM access sequencer and its surroundings:
// operator controls, the board RAM pins and the 7-seg display stage.
interface ram_access_sequencer_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 4
);
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              clear_req;
  logic              scan_en;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;
  logic              busy;

  modport master (
    output wr_req, wr_addr, wr_data, clear_req, scan_en, ram_q,
    input  ram_address, ram_data, ram_wren, disp_addr, disp_data, disp_valid, busy
  );

  modport slave (
    input  wr_req, wr_addr, wr_data, clear_req, scan_en, ram_q,
    output ram_address, ram_data, ram_wren, disp_addr, disp_data, disp_valid, busy
  );
endinterface

// File: rtl/ram_access_sequencer.sv
// Arbitrates manual writes, a full clear sweep and a periodic auto-scan read
// of the board RAM; the last scanned address/data pair feeds the display.
module ram_access_sequencer #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 4,
  parameter int TICK_DIV = 50_000_000
) (
  input logic                    clock,
  input logic                    reset,
  ram_access_sequencer_if.slave  bus
);

  localparam int                TICK_W    = $clog2(TICK_DIV);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    CLEAR,
    SCAN_RD,
    SCAN_LATCH
  } state_t;

  state_t state, next_state;

  logic [TICK_W-1:0] tick_cnt;
  logic              tick_pend;
  logic              tick_hit;
  logic              take_scan;
  logic [ADDR_W-1:0] scan_ptr, scan_ptr_nxt;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_nxt;

  logic [ADDR_W-1:0] ram_address_q, ram_address_nxt;
  logic [DATA_W-1:0] ram_data_q, ram_data_nxt;
  logic              ram_wren_q, ram_wren_nxt;
  logic              busy_q, busy_nxt;
  logic [ADDR_W-1:0] disp_addr_q, disp_addr_nxt;
  logic [DATA_W-1:0] disp_data_q, disp_data_nxt;
  logic              disp_valid_q, disp_valid_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.clear_req) begin
          next_state = CLEAR;
        end else if (bus.wr_req) begin
          next_state = WRITE;
        end else if (tick_pend) begin
          next_state = SCAN_RD;
        end
      end
      WRITE:      next_state = IDLE;
      CLEAR:      next_state = (clr_ptr == LAST_ADDR) ? IDLE : CLEAR;
      SCAN_RD:    next_state = SCAN_LATCH;
      SCAN_LATCH: next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  assign take_scan = (state == IDLE) && (next_state == SCAN_RD);
  assign tick_hit  = bus.scan_en && (tick_cnt == TICK_LAST);

  // Pin values are computed for the state being entered, so the registered
  // outputs line up with the state they belong to.
  always_comb begin
    ram_address_nxt = ram_address_q;
    ram_data_nxt    = '0;
    ram_wren_nxt    = 1'b0;
    busy_nxt        = 1'b0;
    clr_ptr_nxt     = clr_ptr;
    scan_ptr_nxt    = scan_ptr;
    disp_addr_nxt   = disp_addr_q;
    disp_data_nxt   = disp_data_q;
    disp_valid_nxt  = 1'b0;

    case (next_state)
      WRITE: begin
        ram_address_nxt = bus.wr_addr;
        ram_data_nxt    = bus.wr_data;
        ram_wren_nxt    = 1'b1;
      end
      CLEAR: begin
        clr_ptr_nxt     = (state == CLEAR) ? clr_ptr + 1'b1 : '0;
        ram_address_nxt = clr_ptr_nxt;
        ram_wren_nxt    = 1'b1;
        busy_nxt        = 1'b1;
      end
      SCAN_RD, SCAN_LATCH: begin
        ram_address_nxt = scan_ptr;
      end
      default: begin
      end
    endcase

    // RAM q is valid during SCAN_LATCH, one clock after the scan address.
    if (state == SCAN_LATCH) begin
      disp_addr_nxt  = scan_ptr;
      disp_data_nxt  = bus.ram_q;
      disp_valid_nxt = 1'b1;
      scan_ptr_nxt   = scan_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tick_cnt      <= '0;
      tick_pend     <= 1'b0;
      scan_ptr      <= '0;
      clr_ptr       <= '0;
      ram_address_q <= '0;
      ram_data_q    <= '0;
      ram_wren_q    <= 1'b0;
      busy_q        <= 1'b0;
      disp_addr_q   <= '0;
      disp_data_q   <= '0;
      disp_valid_q  <= 1'b0;
    end else begin
      if (!bus.scan_en) begin
        tick_cnt  <= '0;
        tick_pend <= 1'b0;
      end else begin
        tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
        // A fresh terminal count wins over consumption so no tick is lost.
        if (tick_hit) begin
          tick_pend <= 1'b1;
        end else if (take_scan) begin
          tick_pend <= 1'b0;
        end
      end
      scan_ptr      <= scan_ptr_nxt;
      clr_ptr       <= clr_ptr_nxt;
      ram_address_q <= ram_address_nxt;
      ram_data_q    <= ram_data_nxt;
      ram_wren_q    <= ram_wren_nxt;
      busy_q        <= busy_nxt;
      disp_addr_q   <= disp_addr_nxt;
      disp_data_q   <= disp_data_nxt;
      disp_valid_q  <= disp_valid_nxt;
    end
  end

  assign bus.ram_address = ram_address_q;
  assign bus.ram_data    = ram_data_q;
  assign bus.ram_wren    = ram_wren_q;
  assign bus.busy        = busy_q;
  assign bus.disp_addr   = disp_addr_q;
  assign bus.disp_data   = disp_data_q;
  assign bus.disp_valid  = disp_valid_q;

endmodule

// File: tb/tb_ram_access_sequencer.sv
// Bench for ram_access_sequencer: behavioural 1-cycle-latency RAM, reference
// memory/scan-pointer model, and a scoreboard checked by a display monitor.
module tb_ram_access_sequencer;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 4;
  localparam int TICK_DIV = 4;
  localparam int DEPTH    = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } disp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  ram_access_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_access_sequencer #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TICK_DIV(TICK_DIV)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // Board RAM: registered address/data/wren, q follows the registered address.
  logic [DATA_W-1:0] mem      [DEPTH];
  logic [DATA_W-1:0] init_val [DEPTH];
  logic [ADDR_W-1:0] raddr;
  logic              ram_init = 1'b1;

  always @(posedge clock) begin
    if (ram_init) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_val[i];
      raddr <= '0;
    end else begin
      if (bus.ram_wren) mem[bus.ram_address] <= bus.ram_data;
      raddr <= bus.ram_address;
    end
  end

  assign bus.ram_q = mem[raddr];

  logic [DATA_W-1:0] ref_mem [DEPTH];
  int                model_ptr = 0;
  disp_t             exp_q [$];
  int                vectors = 0;
  int                miscompares = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name, input logic [31:0] actual);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: got 0x%0h with nothing expected", name, actual);
  endtask

  // Display monitor: pops the scoreboard on every disp_valid pulse.
  int    cyc = 0;
  int    last_valid_cyc = -1;
  logic  prev_valid = 1'b0;
  disp_t last_seen = '0;
  disp_t got, exp_e;

  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      last_seen      = '0;
      prev_valid     = 1'b0;
      last_valid_cyc = -1;
    end else if (bus.disp_valid) begin
      got = {bus.disp_addr, bus.disp_data};
      checkOutput("disp_pulse_width", 32'(prev_valid), 32'd0);
      if (last_valid_cyc >= 0)
        checkOutput("disp_spacing", 32'((cyc - last_valid_cyc) >= TICK_DIV), 32'd1);
      if (exp_q.size() == 0) begin
        reportFail("disp_unexpected", 32'(got));
      end else begin
        exp_e = exp_q.pop_front();
        checkOutput("disp_pair", 32'(got), 32'(exp_e));
      end
      last_seen      = got;
      last_valid_cyc = cyc;
      prev_valid     = 1'b1;
    end else begin
      checkOutput("disp_hold", 32'({bus.disp_addr, bus.disp_data}), 32'(last_seen));
      prev_valid = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic waitDrain();
    int w = 0;
    while (exp_q.size() != 0 && w < 60) begin
      step(1);
      w++;
    end
    checkOutput("scan_drain_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic checkMemory(input string tag);
    for (int i = 0; i < DEPTH; i++)
      checkOutput($sformatf("%s_mem[%0d]", tag, i), 32'(mem[i]), 32'(ref_mem[i]));
  endtask

  task automatic pushScan(input int n);
    disp_t e;
    for (int k = 0; k < n; k++) begin
      e.addr    = ADDR_W'(model_ptr);
      e.data    = ref_mem[model_ptr];
      exp_q.push_back(e);
      model_ptr = (model_ptr + 1) % DEPTH;
    end
  endtask

  // op 0: manual write, op 1: n scan steps, op 2: clear sweep (inject=1 also
  // fires a write with the clear and a write/clear inside the sweep).
  task automatic applyStimulus(input int op, input int a, input int d, input int n);
    int cnt;
    case (op)
      0: begin
        bus.wr_req  = 1'b1;
        bus.wr_addr = ADDR_W'(a);
        bus.wr_data = DATA_W'(d);
        step(1);
        bus.wr_req  = 1'b0;
        step(1);
        ref_mem[a] = DATA_W'(d);
      end
      1: begin
        pushScan(n);
        bus.scan_en = 1'b1;
        step(TICK_DIV * n + 2);
        bus.scan_en = 1'b0;
        waitDrain();
      end
      default: begin
        bus.clear_req = 1'b1;
        if (n != 0) begin
          bus.wr_req  = 1'b1;
          bus.wr_addr = 5'd20;
          bus.wr_data = 4'd9;
        end
        step(1);
        bus.clear_req = 1'b0;
        bus.wr_req    = 1'b0;
        cnt = 0;
        while (bus.busy && cnt < 100) begin
          checkOutput($sformatf("clear_step%0d", cnt),
                      32'({bus.ram_wren, bus.ram_address, bus.ram_data}),
                      32'({1'b1, ADDR_W'(cnt), DATA_W'(0)}));
          if (n != 0) begin
            bus.wr_req    = (cnt == 5);
            bus.clear_req = (cnt == 8);
          end
          cnt++;
          step(1);
        end
        bus.wr_req    = 1'b0;
        bus.clear_req = 1'b0;
        checkOutput("clear_busy_cycles", 32'(cnt), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      end
    endcase
  endtask

  initial begin
    int cnt;
    bus.wr_req    = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.clear_req = 1'b0;
    bus.scan_en   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      init_val[i] = DATA_W'($urandom_range(1, (1 << DATA_W) - 1));
      ref_mem[i]  = init_val[i];
    end
    step(1);
    ram_init = 1'b0;
    step(2);
    checkOutput("reset_outputs",
                32'({bus.ram_address, bus.ram_data, bus.ram_wren, bus.disp_addr,
                     bus.disp_data, bus.disp_valid, bus.busy}), 32'd0);
    reset = 1'b0;
    step(2);

    $display("[TB] clear sweep with dropped write/clear requests");
    applyStimulus(2, 0, 0, 1);
    step(2);
    checkMemory("after_clear");

    $display("[TB] manual write then 33-step scan");
    applyStimulus(0, 5, 4'hA, 0);
    applyStimulus(1, 0, 0, 33);
    applyStimulus(1, 0, 0, 2);

    $display("[TB] write on tick terminal cycle at scan pointer");
    ref_mem[model_ptr] = 4'd7;
    bus.scan_en = 1'b1;
    step(TICK_DIV - 1);
    bus.wr_req  = 1'b1;
    bus.wr_addr = ADDR_W'(model_ptr);
    bus.wr_data = 4'd7;
    pushScan(1);
    step(1);
    bus.wr_req  = 1'b0;
    step(2);
    bus.scan_en = 1'b0;
    waitDrain();

    $display("[TB] randomized writes, scans and clears");
    for (int r = 0; r < 10; r++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: applyStimulus(0, int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 15)), 0);
        3, 4:    applyStimulus(1, 0, 0, int'($urandom_range(1, 6)));
        default: applyStimulus(2, 0, 0, 0);
      endcase
    end
    for (int r = 0; r < 12; r++)
      applyStimulus(0, int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 15)), 0);
    applyStimulus(1, 0, 0, 3);

    $display("[TB] reset in the middle of a clear sweep");
    bus.clear_req = 1'b1;
    step(1);
    bus.clear_req = 1'b0;
    cnt = 0;
    while (!(bus.busy && bus.ram_address == 5'd9) && cnt < 100) begin
      step(1);
      cnt++;
    end
    checkOutput("clear_reached_addr9", 32'(bus.busy && bus.ram_address == 5'd9), 32'd1);
    reset = 1'b1;
    step(1);
    checkOutput("reset_mid_clear_outputs",
                32'({bus.ram_address, bus.ram_data, bus.ram_wren, bus.disp_addr,
                     bus.disp_data, bus.disp_valid, bus.busy}), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) ref_mem[i] = '0;
    model_ptr = 0;
    step(2);
    checkMemory("partial_clear");
    applyStimulus(1, 0, 0, 4);

    step(4);
    checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
